// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing constants for the divider
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH = 32;
  // one restoring iteration per quotient bit
  localparam int DIV_ITERS = DIV_WIDTH;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  // the partial remainder stays below the divisor, so the borrow bit alone decides
  assign o_q     = ~w_diff[WIDTH];
  assign o_rem   = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - iterative signed/unsigned divider (lo=quotient, hi=remainder)
// Optional macro DIVIDER_ZERO_FAST_EN: divide-by-zero skips the iteration phase.
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int ITERS = DIV_ITERS * WIDTH / DIV_WIDTH;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  div_state_e       r_state;
  div_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div0;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_q;
`ifdef DIVIDER_ZERO_FAST_EN
  logic             w_b_zero;
  assign w_b_zero = (b == '0);
`endif

  assign w_a_neg = is_signed & a[WIDTH-1];
  assign w_b_neg = is_signed & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;
  // a zero divisor yields an all-ones quotient in both modes, never negated
  assign w_div0  = (r_divisor == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_quo[WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = (r_state != S_IDLE);
    done   = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef DIVIDER_ZERO_FAST_EN
          w_next = w_b_zero ? S_FIX : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC:  if (r_cnt == CNT_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_quo starts as the dividend magnitude and shifts quotient bits in from the bottom
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_lo      <= '0;
      r_hi      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_divisor <= w_b_mag;
            r_q_neg   <= w_a_neg ^ w_b_neg;
            r_r_neg   <= w_a_neg;
            r_cnt     <= '0;
            r_quo     <= w_a_mag;
            r_rem     <= '0;
`ifdef DIVIDER_ZERO_FAST_EN
            if (w_b_zero) begin
              r_quo <= '1;
              r_rem <= w_a_mag;
            end
`endif
          end
        end
        S_CALC: begin
          r_rem <= w_step_rem;
          r_quo <= {r_quo[WIDTH-2:0], w_step_q};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_lo <= (r_q_neg && !w_div0) ? -r_quo : r_quo;
          r_hi <= r_r_neg ? -r_rem : r_rem;
        end
        default: ;
      endcase
    end
  end

  assign lo = r_lo;
  assign hi = r_hi;

endmodule
